// File: rtl/up_counter.sv
// Modulo-(MAX+1) up counter with clear, saturating load, terminal-count strobe and sticky overflow.
// Latency: q and ovf update one clk edge after the controls are sampled; tc is combinational.
// Backpressure: none; en is sampled on every edge and there is no stall or handshake.
module up_counter #(
  parameter int N   = 4,
  parameter int MAX = (1 << N) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf
);

  // Terminal value and increment as N-bit constants so every compare and add is width-matched.
  localparam logic [N-1:0] MAX_V = N'(MAX);
  localparam logic [N-1:0] ONE   = N'(1);

  logic         at_max;
  logic [N-1:0] ld_val;
  logic [N-1:0] q_nxt;
  logic         ovf_nxt;

  // Next-state selection with priority clr > ld > en > hold; loads above MAX saturate.
  always_comb begin
    at_max  = (q == MAX_V);
    ld_val  = (d > MAX_V) ? MAX_V : d;
    q_nxt   = q;
    ovf_nxt = ovf;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (ld) begin
      q_nxt   = ld_val;
    end else if (en) begin
      if (at_max) begin
        // Wrap is detected by the compare, so the increment below never has to carry out of N bits.
        q_nxt   = '0;
        ovf_nxt = 1'b1;
      end else begin
        q_nxt   = q + ONE;
      end
    end
  end

  // State register; reset clears count and overflow without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

  // Terminal count flags the cycle whose rising edge performs the wrap.
  assign tc = en && at_max;

endmodule

// File: tb/tb_up_counter.sv
module tb_up_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       ld;
  logic [3:0] d;
  logic [3:0] q15;
  logic       tc15;
  logic       ovf15;
  logic [3:0] q9;
  logic       tc9;
  logic       ovf9;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] q15;
    logic       ovf15;
    logic       tc15;
    logic [3:0] q9;
    logic       ovf9;
    logic       tc9;
  } exp_t;

  exp_t sb[$];

  int m15_q;
  bit m15_ovf;
  int m9_q;
  bit m9_ovf;

  up_counter #(.N(4), .MAX(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ld(ld), .d(d),
    .q(q15), .tc(tc15), .ovf(ovf15)
  );

  up_counter #(.N(4), .MAX(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ld(ld), .d(d),
    .q(q9), .tc(tc9), .ovf(ovf9)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  // Reference behaviour: integer arithmetic modulo mmax+1.
  task automatic model_step(input int mmax, input bit e, input bit l, input bit c,
                            input int dv, inout int mq, inout bit movf);
    if (c) begin
      mq   = 0;
      movf = 0;
    end else if (l) begin
      mq = (dv > mmax) ? mmax : dv;
    end else if (e) begin
      if (mq + 1 > mmax) begin
        mq   = 0;
        movf = 1;
      end else begin
        mq = mq + 1;
      end
    end
  endtask

  task automatic model_reset();
    m15_q = 0; m15_ovf = 0;
    m9_q  = 0; m9_ovf  = 0;
    sb.delete();
  endtask

  // Drive one cycle of controls (called just after a falling edge) and push the expectation.
  task automatic drive(input bit e, input bit l, input bit c, input logic [3:0] dv);
    exp_t x;
    en = e; ld = l; clr = c; d = dv;
    x.tc15 = e && (m15_q == 15);
    x.tc9  = e && (m9_q == 9);
    model_step(15, e, l, c, int'(dv), m15_q, m15_ovf);
    model_step(9,  e, l, c, int'(dv), m9_q,  m9_ovf);
    x.q15 = 4'(m15_q); x.ovf15 = m15_ovf;
    x.q9  = 4'(m9_q);  x.ovf9  = m9_ovf;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; d = 4'd0;
    model_reset();
    #1;
    n_checks++;
    if (q15 !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_q: got %0d want 0", q15);
    end
    en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q15 !== 4'd0) begin
      n_fail++; $display("FAIL reset_q: got %0d want 0", q15);
    end
    n_checks++;
    if (ovf15 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf15);
    end
    n_checks++;
    if (tc15 !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc: got %b want 0", tc15);
    end
    #250;
    n_checks++;
    if (q15 !== 4'd0 || q9 !== 4'd0) begin
      n_fail++; $display("FAIL reset_between_edges: got %0d/%0d want 0/0", q15, q9);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_enable_low();
    exp_t x;
    logic tc_obs;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      #1 tc_obs = tc15;
      @(posedge clk);
      @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q15 !== x.q15) begin
        n_fail++; $display("FAIL en_low_q[%0d]: got %0d want %0d", i, q15, x.q15);
      end
      n_checks++;
      if (tc_obs !== x.tc15) begin
        n_fail++; $display("FAIL en_low_tc[%0d]: got %b want %b", i, tc_obs, x.tc15);
      end
    end
  endtask

  task automatic test_count_wrap();
    exp_t x;
    logic tc_obs;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      #1 tc_obs = tc15;
      @(posedge clk);
      @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q15 !== x.q15) begin
        n_fail++; $display("FAIL count_q[%0d]: got %0d want %0d", i, q15, x.q15);
      end
      n_checks++;
      if (ovf15 !== x.ovf15) begin
        n_fail++; $display("FAIL count_ovf[%0d]: got %b want %b", i, ovf15, x.ovf15);
      end
      n_checks++;
      if (tc_obs !== x.tc15) begin
        n_fail++; $display("FAIL count_tc[%0d]: got %b want %b", i, tc_obs, x.tc15);
      end
    end
  endtask

  task automatic test_load_clear();
    // {en, ld, clr, d}: plain load, load beating en, clr beating ld/en, hold, count, en with ld at 15.
    logic [6:0] tbl [7] = '{
      {1'b0, 1'b1, 1'b0, 4'd9},
      {1'b1, 1'b1, 1'b0, 4'd3},
      {1'b1, 1'b1, 1'b1, 4'd5},
      {1'b0, 1'b0, 1'b0, 4'd7},
      {1'b1, 1'b0, 1'b0, 4'd7},
      {1'b0, 1'b1, 1'b0, 4'd15},
      {1'b1, 1'b0, 1'b0, 4'd0}
    };
    exp_t x;
    logic tc_obs;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3:0]);
      #1 tc_obs = tc15;
      @(posedge clk);
      @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q15 !== x.q15) begin
        n_fail++; $display("FAIL ldclr_q[%0d]: got %0d want %0d", i, q15, x.q15);
      end
      n_checks++;
      if (ovf15 !== x.ovf15) begin
        n_fail++; $display("FAIL ldclr_ovf[%0d]: got %b want %b", i, ovf15, x.ovf15);
      end
      n_checks++;
      if (tc_obs !== x.tc15) begin
        n_fail++; $display("FAIL ldclr_tc[%0d]: got %b want %b", i, tc_obs, x.tc15);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t x;
    // Load 14, wrap once to set ovf, then count up to 7.
    drive(1'b0, 1'b1, 1'b0, 4'd14);
    @(posedge clk); @(negedge clk);
    void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      @(posedge clk); @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q15 !== x.q15 || ovf15 !== x.ovf15) begin
        n_fail++; $display("FAIL midrst_pre[%0d]: got q=%0d ovf=%b want q=%0d ovf=%b",
                           i, q15, ovf15, x.q15, x.ovf15);
      end
    end
    en = 1'b0;
    #200 rst_n = 1'b0;
    #1;
    n_checks++;
    if (q15 !== 4'd0) begin
      n_fail++; $display("FAIL midrst_q: got %0d want 0", q15);
    end
    n_checks++;
    if (ovf15 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ovf: got %b want 0", ovf15);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      @(posedge clk); @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q15 !== x.q15) begin
        n_fail++; $display("FAIL midrst_resume[%0d]: got %0d want %0d", i, q15, x.q15);
      end
    end
  endtask

  task automatic test_modulus();
    exp_t x;
    logic tc_obs;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    @(posedge clk); @(negedge clk);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b0, 4'd12);
    @(posedge clk); @(negedge clk);
    x = sb.pop_front();
    n_checks++;
    if (q9 !== x.q9) begin
      n_fail++; $display("FAIL mod_satload: got %0d want %0d", q9, x.q9);
    end
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      #1 tc_obs = tc9;
      @(posedge clk);
      @(negedge clk);
      x = sb.pop_front();
      n_checks++;
      if (q9 !== x.q9) begin
        n_fail++; $display("FAIL mod_q[%0d]: got %0d want %0d", i, q9, x.q9);
      end
      n_checks++;
      if (ovf9 !== x.ovf9) begin
        n_fail++; $display("FAIL mod_ovf[%0d]: got %b want %b", i, ovf9, x.ovf9);
      end
      n_checks++;
      if (tc_obs !== x.tc9) begin
        n_fail++; $display("FAIL mod_tc[%0d]: got %b want %b", i, tc_obs, x.tc9);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enable_low();
    test_count_wrap();
    test_load_clear();
    test_mid_reset();
    test_modulus();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
